// File: rtl/dram_pkg.sv
// Shared DRAM sequencer types: command states, default geometry and the
// per-bank open-row entry.
package dram_pkg;

    localparam int DRAM_BANK_BITS = 4;
    localparam int DRAM_ROW_BITS  = 16;

    typedef enum logic [3:0] {
        IDLE,
        ACTIVATE,
        ACTIVATING,
        READ,
        READING,
        WRITE,
        WRITING,
        PRECHARGE,
        PRECHARGING,
        REFRESH,
        REFRESHING
    } cmd_state_t;

    typedef struct packed {
        logic                     valid;
        logic [DRAM_ROW_BITS-1:0] row;
    } bank_row_t;

endpackage

// File: rtl/command_fsm_open_row_table.sv
// Per-bank open-row table: one bank_row_t per bank, combinational lookup,
// synchronous set / clear-one / clear-all, async active-low reset.
module open_row_table
    import dram_pkg::*;
#(
    parameter int BANK_BITS = DRAM_BANK_BITS,
    parameter int ROW_BITS  = DRAM_ROW_BITS
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [BANK_BITS-1:0] lookup_bank,
    input  logic [ROW_BITS-1:0]  lookup_row,
    output logic                 lookup_open,
    output logic                 lookup_hit,
    output logic                 any_open,
    input  logic                 set_en,
    input  logic [BANK_BITS-1:0] set_bank,
    input  logic [ROW_BITS-1:0]  set_row,
    input  logic                 clr_en,
    input  logic [BANK_BITS-1:0] clr_bank,
    input  logic                 clr_all
);

    localparam int NUM_BANKS = 1 << BANK_BITS;

    bank_row_t entries [NUM_BANKS];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                entries[i] <= '0;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (clr_en) begin
                entries[clr_bank].valid <= 1'b0;
            end
            if (set_en) begin
                entries[set_bank].valid <= 1'b1;
                entries[set_bank].row   <= set_row;
            end
        end
    end

    assign lookup_open = entries[lookup_bank].valid;
    assign lookup_hit  = entries[lookup_bank].valid && (entries[lookup_bank].row == lookup_row);

    always_comb begin
        any_open = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            any_open = any_open | entries[i].valid;
        end
    end

endmodule

// File: rtl/command_fsm.sv
// DRAM command sequencer: one request at a time, open-page row tracking,
// refresh deferred to IDLE. Define CLOSED_PAGE_EN to precharge after every access.
module command_fsm
    import dram_pkg::*;
#(
    parameter int BANK_BITS = 4,
    parameter int ROW_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [BANK_BITS-1:0] req_bank,
    input  logic [ROW_BITS-1:0]  req_row,
    output logic                 req_ready,
    output logic                 req_done,
    input  logic                 tACT_done,
    input  logic                 tRD_done,
    input  logic                 tWR_done,
    input  logic                 tPRE_done,
    input  logic                 tREF_done,
    input  logic                 rf_req,
    output cmd_state_t           cmd_state,
    output logic [BANK_BITS-1:0] cmd_bank,
    output logic [ROW_BITS-1:0]  cmd_row,
    output logic                 pre_all
);

    logic op_write;
    logic lookup_open;
    logic lookup_hit;
    logic any_open;
    logic set_en;
    logic clr_en;
    logic clr_all;

    assign req_ready = (cmd_state == IDLE) && !rf_req;

    // Table updates happen on the same edge that leaves the matching wait state.
    assign set_en  = (cmd_state == ACTIVATING) && tACT_done;
    assign clr_all = (cmd_state == PRECHARGING) && tPRE_done && pre_all;
    assign clr_en  = (cmd_state == PRECHARGING) && tPRE_done && !pre_all;

    open_row_table #(
        .BANK_BITS (BANK_BITS),
        .ROW_BITS  (ROW_BITS)
    ) u_open_row_table (
        .clk         (clk),
        .nRST        (nRST),
        .lookup_bank (req_bank),
        .lookup_row  (req_row),
        .lookup_open (lookup_open),
        .lookup_hit  (lookup_hit),
        .any_open    (any_open),
        .set_en      (set_en),
        .set_bank    (cmd_bank),
        .set_row     (cmd_row),
        .clr_en      (clr_en),
        .clr_bank    (cmd_bank),
        .clr_all     (clr_all)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cmd_state <= IDLE;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            pre_all   <= 1'b0;
            req_done  <= 1'b0;
            op_write  <= 1'b0;
        end else begin
            req_done <= 1'b0;
            unique case (cmd_state)
                IDLE: begin
                    if (rf_req) begin
                        pre_all   <= any_open;
                        cmd_state <= any_open ? PRECHARGE : REFRESH;
                    end else if (req_valid) begin
                        op_write <= req_write;
                        cmd_bank <= req_bank;
                        cmd_row  <= req_row;
                        pre_all  <= 1'b0;
                        if (lookup_hit) begin
                            cmd_state <= req_write ? WRITE : READ;
                        end else if (lookup_open) begin
                            cmd_state <= PRECHARGE;
                        end else begin
                            cmd_state <= ACTIVATE;
                        end
                    end
                end
                ACTIVATE:  cmd_state <= ACTIVATING;
                READ:      cmd_state <= READING;
                WRITE:     cmd_state <= WRITING;
                PRECHARGE: cmd_state <= PRECHARGING;
                REFRESH:   cmd_state <= REFRESHING;
                ACTIVATING: begin
                    if (tACT_done) begin
                        cmd_state <= op_write ? WRITE : READ;
                    end
                end
                READING, WRITING: begin
                    if ((cmd_state == READING && tRD_done) || (cmd_state == WRITING && tWR_done)) begin
                        req_done <= 1'b1;
`ifdef CLOSED_PAGE_EN
                        cmd_state <= PRECHARGE;
`else
                        cmd_state <= IDLE;
`endif
                    end
                end
                PRECHARGING: begin
                    if (tPRE_done) begin
                        if (pre_all) begin
                            cmd_state <= REFRESH;
                        end else begin
`ifdef CLOSED_PAGE_EN
                            cmd_state <= IDLE;
`else
                            cmd_state <= ACTIVATE;
`endif
                        end
                    end
                end
                REFRESHING: begin
                    if (tREF_done) begin
                        pre_all   <= 1'b0;
                        cmd_state <= IDLE;
                    end
                end
                default: cmd_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_fsm.sv
// Scoreboard bench for command_fsm: expected state visits are queued as each
// request is driven and popped whenever the DUT changes state.
module tb_command_fsm;
    import dram_pkg::*;

    typedef struct packed {
        cmd_state_t  st;
        logic [3:0]  bank;
        logic [15:0] row;
        logic        pa;
        logic        done;
    } exp_t;

    logic        tb_CLK;
    logic        nRST;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_bank;
    logic [15:0] req_row;
    logic        req_ready;
    logic        req_done;
    logic        tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done;
    logic        rf_req;
    cmd_state_t  cmd_state;
    logic [3:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic        pre_all;

    logic [4:0]  dones;
    exp_t        sb [$];
    int          tests_run;
    int          tests_failed;
    int          tmr_delay;
    logic        mon_en;
    cmd_state_t  mon_prev;

    assign {tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done} = dones;

    command_fsm #(.BANK_BITS(4), .ROW_BITS(16)) dut (
        .clk       (tb_CLK),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_bank  (req_bank),
        .req_row   (req_row),
        .req_ready (req_ready),
        .req_done  (req_done),
        .tACT_done (tACT_done),
        .tRD_done  (tRD_done),
        .tWR_done  (tWR_done),
        .tPRE_done (tPRE_done),
        .tREF_done (tREF_done),
        .rf_req    (rf_req),
        .cmd_state (cmd_state),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .pre_all   (pre_all)
    );

    initial tb_CLK = 1'b0;
    always #5 tb_CLK = ~tb_CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pushExp(input cmd_state_t st, input logic [3:0] b, input logic [15:0] r,
                           input logic pa, input logic done);
        exp_t e;
        e.st = st; e.bank = b; e.row = r; e.pa = pa; e.done = done;
        sb.push_back(e);
    endtask

    task automatic pushAct(input logic [3:0] b, input logic [15:0] r);
        pushExp(ACTIVATE, b, r, 1'b0, 1'b0);
        pushExp(ACTIVATING, b, r, 1'b0, 1'b0);
    endtask

    task automatic pushTail(input logic w, input logic [3:0] b, input logic [15:0] r);
        pushExp(w ? WRITE : READ, b, r, 1'b0, 1'b0);
        pushExp(w ? WRITING : READING, b, r, 1'b0, 1'b0);
`ifdef CLOSED_PAGE_EN
        pushExp(PRECHARGE, b, r, 1'b0, 1'b1);
        pushExp(PRECHARGING, b, r, 1'b0, 1'b0);
        pushExp(IDLE, b, r, 1'b0, 1'b0);
`else
        pushExp(IDLE, b, r, 1'b0, 1'b1);
`endif
    endtask

    // Called at a falling edge; holds the request until the DUT takes it.
    task automatic applyStimulus(input logic w, input logic [3:0] b, input logic [15:0] r);
        int n;
        req_valid = 1'b1; req_write = w; req_bank = b; req_row = r;
        n = 0;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge tb_CLK);
            #1;
            n++;
        end
        if (!req_ready) checkOutput("accept_timeout", 32'(req_ready), 32'd1);
        @(negedge tb_CLK);
        req_valid = 1'b0;
    endtask

    task automatic waitState(input cmd_state_t s);
        int n;
        n = 0;
        while (cmd_state != s && n < 50) begin
            @(negedge tb_CLK);
            n++;
        end
        if (cmd_state != s) checkOutput("wait_state", 32'(cmd_state), 32'(s));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge tb_CLK);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge tb_CLK);
    endtask

    // Timer model: each wait state expires after tmr_delay cycles; on entry
    // every non-matching done is pulsed once and must be ignored.
    initial begin : responder
        cmd_state_t rsp_state;
        int         rsp_cnt;
        logic [4:0] own;
        dones     = 5'b0;
        rsp_state = IDLE;
        rsp_cnt   = 0;
        forever begin
            @(negedge tb_CLK);
            dones = 5'b0;
            if (cmd_state != rsp_state) begin
                rsp_state = cmd_state;
                rsp_cnt   = 0;
            end else begin
                rsp_cnt++;
            end
            case (cmd_state)
                ACTIVATING:  own = 5'b10000;
                READING:     own = 5'b01000;
                WRITING:     own = 5'b00100;
                PRECHARGING: own = 5'b00010;
                REFRESHING:  own = 5'b00001;
                default:     own = 5'b00000;
            endcase
            if (own != 5'b0) begin
                if (rsp_cnt == tmr_delay) dones = own;
                else if (rsp_cnt == 0)    dones = ~own;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge tb_CLK);
            if (mon_en) begin
                if (cmd_state != mon_prev) begin
                    if (sb.size() == 0) begin
                        checkOutput("state_unexpected", 32'(cmd_state), 32'(mon_prev));
                    end else begin
                        e = sb.pop_front();
                        checkOutput("cmd_state", 32'(cmd_state), 32'(e.st));
                        checkOutput("cmd_bank", 32'(cmd_bank), 32'(e.bank));
                        checkOutput("cmd_row", 32'(cmd_row), 32'(e.row));
                        checkOutput("pre_all", 32'(pre_all), 32'(e.pa));
                        checkOutput("req_done", 32'(req_done), 32'(e.done));
                    end
                    mon_prev = cmd_state;
                end else begin
                    checkOutput("req_done_quiet", 32'(req_done), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        tests_run = 0; tests_failed = 0; tmr_delay = 2;
        mon_en = 1'b0; mon_prev = IDLE;
        nRST = 1'b0; rf_req = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_row = '0;

        repeat (2) @(negedge tb_CLK);
        #1;
        checkOutput("rst_state", 32'(cmd_state), 32'(IDLE));
        checkOutput("rst_bank", 32'(cmd_bank), 32'd0);
        checkOutput("rst_row", 32'(cmd_row), 32'd0);
        checkOutput("rst_pre_all", 32'(pre_all), 32'd0);
        checkOutput("rst_done", 32'(req_done), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        @(negedge tb_CLK);
        nRST = 1'b1;
        mon_en = 1'b1;
        @(negedge tb_CLK);

        // Cold read, then the same row again.
        pushAct(4'd2, 16'h0010);
        pushTail(1'b0, 4'd2, 16'h0010);
        applyStimulus(1'b0, 4'd2, 16'h0010);
        waitDrain();

`ifdef CLOSED_PAGE_EN
        pushAct(4'd2, 16'h0010);
`endif
        pushTail(1'b0, 4'd2, 16'h0010);
        applyStimulus(1'b0, 4'd2, 16'h0010);
        waitDrain();

        // Write to a different row of the same bank.
`ifndef CLOSED_PAGE_EN
        pushExp(PRECHARGE, 4'd2, 16'h0020, 1'b0, 1'b0);
        pushExp(PRECHARGING, 4'd2, 16'h0020, 1'b0, 1'b0);
`endif
        pushAct(4'd2, 16'h0020);
        pushTail(1'b1, 4'd2, 16'h0020);
        applyStimulus(1'b1, 4'd2, 16'h0020);
        waitDrain();

        // Refresh raised mid-write is deferred until the write retires.
`ifdef CLOSED_PAGE_EN
        pushAct(4'd2, 16'h0020);
        pushTail(1'b1, 4'd2, 16'h0020);
        pushExp(REFRESH, 4'd2, 16'h0020, 1'b0, 1'b0);
        pushExp(REFRESHING, 4'd2, 16'h0020, 1'b0, 1'b0);
`else
        pushTail(1'b1, 4'd2, 16'h0020);
        pushExp(PRECHARGE, 4'd2, 16'h0020, 1'b1, 1'b0);
        pushExp(PRECHARGING, 4'd2, 16'h0020, 1'b1, 1'b0);
        pushExp(REFRESH, 4'd2, 16'h0020, 1'b1, 1'b0);
        pushExp(REFRESHING, 4'd2, 16'h0020, 1'b1, 1'b0);
`endif
        pushExp(IDLE, 4'd2, 16'h0020, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 16'h0020);
        waitState(WRITING);
        rf_req = 1'b1;
        waitState(REFRESH);
        rf_req = 1'b0;
        waitDrain();

        // Refresh and request together with every bank closed.
        rf_req = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_bank = 4'd2; req_row = 16'h0020;
        #1;
        checkOutput("ready_refresh_stall", 32'(req_ready), 32'd0);
        pushExp(REFRESH, 4'd2, 16'h0020, 1'b0, 1'b0);
        pushExp(REFRESHING, 4'd2, 16'h0020, 1'b0, 1'b0);
        pushExp(IDLE, 4'd2, 16'h0020, 1'b0, 1'b0);
        pushAct(4'd2, 16'h0020);
        pushTail(1'b1, 4'd2, 16'h0020);
        waitState(REFRESH);
        rf_req = 1'b0;
        begin
            int n;
            n = 0;
            #1;
            while (!req_ready && n < 50) begin
                @(negedge tb_CLK);
                #1;
                n++;
            end
        end
        @(negedge tb_CLK);
        req_valid = 1'b0;
        checkOutput("accept_after_refresh", 32'(cmd_state), 32'(ACTIVATE));
        waitDrain();

        // Reset in the middle of ACTIVATING.
        tmr_delay = 20;
        pushAct(4'd5, 16'h0300);
        pushExp(IDLE, 4'd0, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd5, 16'h0300);
        waitState(ACTIVATING);
        repeat (3) @(negedge tb_CLK);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(cmd_state), 32'(IDLE));
        checkOutput("midrst_bank", 32'(cmd_bank), 32'd0);
        checkOutput("midrst_row", 32'(cmd_row), 32'd0);
        @(negedge tb_CLK);
        nRST = 1'b1;
        tmr_delay = 2;
        waitDrain();

        // The table was wiped, so bank 2 must be activated again.
        pushAct(4'd2, 16'h0020);
        pushTail(1'b0, 4'd2, 16'h0020);
        applyStimulus(1'b0, 4'd2, 16'h0020);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/command_fsm.md
Name: command_fsm

Overview:
DRAM command sequencer.
- Accepts one read/write request at a time from the scheduler.
- Tracks open rows per bank (open-page policy).
- Steps cmd_state through ACT/RD/WR/PRE/REF command and wait states.
- Paired with timing_control: it drives cmd_state into timing_control and consumes that block's t*_done and rf_req outputs to leave each wait state.

Parameters:
BANK_BITS, 4, total bank select bits (bank group + bank); 2^BANK_BITS banks
ROW_BITS, 16, row address width

Ports:
clk  in  1  system clock
nRST  in  1  asynchronous active-low reset
req_valid  in  1  scheduler has a request
req_write  in  1  1=write, 0=read
req_bank  in  BANK_BITS  target bank
req_row  in  ROW_BITS  target row
req_ready  out  1  request accepted this cycle when req_valid&req_ready
req_done  out  1  one-cycle pulse at request completion
tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done  in  1 each  timer expiries from timing_control
rf_req  in  1  refresh due (level, held until REFRESH is entered)
cmd_state  out  cmd_state_t  current command state (dram_pkg enum)
cmd_bank  out  BANK_BITS  bank of the current command
cmd_row  out  ROW_BITS  row of the current command
pre_all  out  1  current PRECHARGE targets all banks

Behaviour:
- Reset (async, nRST=0):
  - cmd_state=IDLE; cmd_bank=0, cmd_row=0, pre_all=0, req_done=0.
  - All open-row valid bits cleared.
  - Applies mid-operation from any state.
- req_ready is combinational: (cmd_state==IDLE && !rf_req).
- On accept, latch write/bank/row into cmd_* / op registers.
- IDLE transitions, evaluated in priority order:
  1. rf_req: any bank open -> PRECHARGE with pre_all=1; otherwise -> REFRESH.
  2. Accept with bank open and row hit -> READ or WRITE.
  3. Accept with bank open and row miss -> PRECHARGE with pre_all=0.
  4. Accept with bank closed -> ACTIVATE.
- Command states ACTIVATE, READ, WRITE, PRECHARGE, REFRESH last exactly 1 cycle, then go to ACTIVATING, READING, WRITING, PRECHARGING, REFRESHING respectively.
- ACTIVATING: hold until tACT_done. On that edge, set open[bank]={1,row}, then -> READ or WRITE per latched op.
- READING / WRITING: hold until tRD_done / tWR_done, then -> IDLE with req_done=1 for one cycle.
- PRECHARGING: hold until tPRE_done.
  - pre_all=1: clear all valid bits -> REFRESH.
  - pre_all=0: clear open[bank] -> ACTIVATE.
- REFRESHING: hold until tREF_done -> IDLE; pre_all cleared.
- rf_req asserting during a transaction is deferred to the next IDLE; an in-flight request is never aborted.
- A t*_done not matching the current wait state is ignored.
- rf_req and req_valid in the same IDLE cycle: refresh wins, request stalls (req_ready=0).
- cmd_* outputs are registered; stable for the whole command and wait-state pair.

Optional Feature:
CLOSED_PAGE_EN
- Defined: READING/WRITING on done -> PRECHARGE (pre_all=0) of the same bank. req_done still pulses on tRD_done/tWR_done. After PRECHARGING, the next state is IDLE instead of ACTIVATE. The table never holds an open bank in IDLE, so every request goes through ACTIVATE.
- Undefined: open-page behaviour as above.

Decomposition:
- dram_pkg: existing cmd_state_t enum; add BANK_BITS/ROW_BITS defaults and a bank_row_t struct {valid, row}.
- Sub-module open_row_table:
  - 2^BANK_BITS x bank_row_t registers.
  - Lookup port (bank -> hit/open).
  - Set port (bank, row).
  - Clear-one and clear-all ports.
  - Async active-low reset.

Test Plan:
1. Reset, then req read bank 2 row 0x0010 (cold) -> ACTIVATE 1 cycle, ACTIVATING until tACT_done, READ, READING; req_done pulse 1 cycle after tRD_done; back to IDLE.
2. Repeat read bank 2 row 0x0010 (hit) -> IDLE->READ directly, no ACTIVATE; cmd_row=0x0010.
3. Write bank 2 row 0x0020 (miss) -> PRECHARGE (pre_all=0, cmd_bank=2), ACTIVATE row 0x0020, WRITE, WRITING; req_done after tWR_done.
4. rf_req=1 during WRITING -> write completes; next IDLE -> PRECHARGE pre_all=1 -> REFRESH -> REFRESHING; IDLE after tREF_done; all banks closed (next req to bank 2 row 0x0020 activates).
5. rf_req and req_valid together in IDLE with no open banks -> req_ready=0, direct REFRESH; request accepted on first IDLE after tREF_done.
6. Assert nRST low during ACTIVATING -> cmd_state=IDLE immediately; bank table cleared. With CLOSED_PAGE_EN, scenario 2 instead goes PRECHARGE->IDLE then ACTIVATE again.
